word_accum: RTL and testbench



---
 rtl/word_accum_pkg.sv | 13 +
 rtl/M.sv | 16 +
 rtl/word_accum.sv | 95 +++++++++
 tb/tb_word_accum.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/word_accum_pkg.sv
// word_accum shared types and constants.
// Frame FSM states and datapath width.
package word_accum_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/M.sv
// M: 32-bit wrapping adder feeding word_accum.
// Purely combinational; no carry-out port.
module M
    import word_accum_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_a
);

    // Modulo-2^32 sum
    always_comb begin
        o_a = i_a + i_b;
    end

endmodule

// File: rtl/word_accum.sv
// word_accum: per-frame running sum of a 32-bit word stream.
// One wrapped sum plus wrap flag per frame of i_len words.
module word_accum
    import word_accum_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [CNT_W-1:0]  i_len,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_ovf
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]  add_a;
    logic [DATA_W-1:0]  add_sum;
    logic               accept;

    M u_M (
        .i_a (add_a),
        .i_b (i_data),
        .o_a (add_sum)
    );

    // Output and handshake decode from state/registers only
    always_comb begin
        o_ready = (state_q != S_HOLD);
        o_valid = (state_q == S_HOLD);
        o_sum   = acc_q;
        o_ovf   = ovf_q;
        accept  = i_valid && (state_q != S_HOLD);
        add_a   = (state_q == S_IDLE) ? '0 : acc_q;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = add_sum;
                    ovf_d   = 1'b0;
                    rem_d   = i_len - CNT_W'(1);
                    state_d = (i_len == CNT_W'(1)) ? S_HOLD : S_ACC;
                end
            end
            S_ACC: begin
                if (accept) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | (add_sum < acc_q);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_word_accum.sv
// tb_word_accum: directed self-checking bench for word_accum.
// Inputs driven and outputs sampled on the falling edge.
module tb_word_accum;

    logic        clk;
    logic        rst_n;
    logic [7:0]  i_len;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_sum;
    logic        o_ovf;

    int errors = 0;
    int checks = 0;

    word_accum #(.CNT_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_len   (i_len),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_ovf   (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word for one cycle (starts and ends at a falling edge)
    task automatic push(input logic [31:0] d, input logic [7:0] len);
        i_valid = 1'b1;
        i_data  = d;
        i_len   = len;
        @(negedge clk);
        i_valid = 1'b0;
        i_data  = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_len   = 8'd0;
        i_data  = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs got v=%b r=%b exp v=0 r=1", o_valid, o_ready);
        end
        checks++;
        if (o_sum !== 32'h0 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got sum=%h ovf=%b exp 0/0", o_sum, o_ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        i_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_pre%0d got r=%b v=%b exp r=1 v=0", k, o_ready, o_valid);
            end
            push(32'(k), 8'd3);
        end
        checks++;
        if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold got v=%b r=%b exp v=1 r=0", o_valid, o_ready);
        end
        checks++;
        if (o_sum !== 32'd6 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum got %h ovf=%b exp 6 ovf=0", o_sum, o_ovf);
        end
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_post got v=%b r=%b exp v=0 r=1", o_valid, o_ready);
        end
    endtask

    task automatic test_overflow();
        i_ready = 1'b1;
        push(32'hFFFF_FFFF, 8'd2);
        push(32'h0000_0002, 8'd2);
        checks++;
        if (o_valid !== 1'b1 || o_sum !== 32'h1 || o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wrap got v=%b sum=%h ovf=%b exp 1/1/1", o_valid, o_sum, o_ovf);
        end
        @(negedge clk);
        push(32'h5, 8'd1);
        checks++;
        if (o_valid !== 1'b1 || o_sum !== 32'h5 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got v=%b sum=%h ovf=%b exp 1/5/0", o_valid, o_sum, o_ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        i_data  = 32'h1234_5678;
        @(negedge clk);
        push(32'hA5, 8'd1);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (o_valid !== 1'b1 || o_sum !== 32'hA5 || o_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b sum=%h r=%b exp 1/a5/0", k, o_valid, o_sum, o_ready);
            end
            if (k < 4) begin
                i_valid = 1'b1;
                @(negedge clk);
                i_valid = 1'b0;
            end
        end
        i_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", o_valid, o_ready);
        end
    endtask

    task automatic test_long_frame();
        int sent = 0;
        int cyc  = 0;
        int early = 0;
        i_ready = 1'b1;
        i_len   = 8'd0;
        i_data  = 32'h1;
        while (sent < 256 && cyc < 3000) begin
            if (o_valid) early++;
            i_valid = (sent == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (sent > 0) i_len = 8'($urandom_range(1, 255));
            if (i_valid && o_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        i_valid = 1'b0;
        i_len   = 8'd0;
        checks++;
        if (sent != 256 || early != 0) begin
            errors++;
            $display("FAIL long_accepts got %0d early=%0d exp 256 early=0", sent, early);
        end
        checks++;
        if (o_valid !== 1'b1 || o_sum !== 32'h100 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL long_sum got v=%b sum=%h ovf=%b exp 1/100/0", o_valid, o_sum, o_ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        i_ready = 1'b1;
        push(32'd1, 8'd4);
        push(32'd2, 8'd4);
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_sum !== 32'h0 || o_ovf !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_during got v=%b sum=%h ovf=%b r=%b exp 0/0/0/1", o_valid, o_sum, o_ovf, o_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_sum !== 32'h0 || o_ovf !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_after got v=%b sum=%h ovf=%b r=%b exp 0/0/0/1", o_valid, o_sum, o_ovf, o_ready);
        end
        push(32'd5, 8'd2);
        push(32'd7, 8'd2);
        checks++;
        if (o_valid !== 1'b1 || o_sum !== 32'd12 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_newframe got v=%b sum=%h ovf=%b exp 1/c/0", o_valid, o_sum, o_ovf);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_long_frame();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
